// File: rtl/stamp_ctrl_pkg.sv
// stamp_ctrl_pkg: shared state encoding, CRC polynomial and counter sizing for the stamp signature controller
package stamp_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  function automatic int win_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/stamp_sig_crc.sv
// stamp_sig_crc: serial CRC-16 register (i_clr clears, i_en absorbs i_bit, o_sig current, o_nxt value after this cycle)
module stamp_sig_crc
  import stamp_ctrl_pkg::*;
#(
  parameter int         W    = 16,
  parameter logic [W-1:0] POLY = CRC_POLY
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_sig,
  output logic [W-1:0] o_nxt
);
  logic w_fb;
  assign w_fb  = o_sig[W-1] ^ i_bit;
  assign o_nxt = i_en ? ({o_sig[W-2:0], 1'b0} ^ (w_fb ? POLY : '0)) : o_sig;
  always_ff @(posedge i_clk)
    o_sig <= (i_rst || i_clr) ? '0 : o_nxt;
endmodule

// File: rtl/stamp_sig_ctrl.sv
// stamp_sig_ctrl: drives stamp-array enables over a capture window and checks the CRC-16 of its XOR output against i_golden
module stamp_sig_ctrl
  import stamp_ctrl_pkg::*;
#(
  parameter int          DUTY_W     = 8,
  parameter int          WINDOW_LEN = 1024,
  parameter int          XOR_LAT    = 3,
  parameter int          SIG_W      = 16,
  parameter logic [15:0] POLY       = CRC_POLY
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [SIG_W-1:0]  i_golden,
  input  logic              i_xor_out,
  output logic              o_stamp_ena,
  output logic              o_xor_ena,
  output logic              o_output_ena,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [SIG_W-1:0]  o_signature
);
  localparam int CW = win_w(WINDOW_LEN);
  localparam int FW = $clog2(XOR_LAT + 1);
  state_t              r_state;
  logic [DUTY_W-1:0]   r_phase;
  logic [CW-1:0]       r_win;
  logic [FW-1:0]       r_fl;
  logic [XOR_LAT-1:0]  r_vld;
  logic [SIG_W-1:0]    w_sig_nxt;
  logic                w_go;
  assign w_go   = i_start && !i_stop && (r_state == IDLE || r_state == DONE);
  assign o_busy = (r_state == RUN) || (r_state == FLUSH);
  assign o_done = (r_state == DONE);
  stamp_sig_crc #(.W(SIG_W), .POLY(POLY)) u_crc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_go),
    .i_en  (r_vld[XOR_LAT-1] && !i_stop),
    .i_bit (i_xor_out),
    .o_sig (o_signature),
    .o_nxt (w_sig_nxt)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_win        <= '0;
      r_fl         <= '0;
      r_vld        <= '0;
      o_stamp_ena  <= 1'b0;
      o_xor_ena    <= 1'b0;
      o_output_ena <= 1'b0;
      o_pass       <= 1'b0;
    end else begin
      r_vld <= XOR_LAT'({r_vld, o_xor_ena});
      if (i_stop) begin
        r_state      <= IDLE;
        r_vld        <= '0;
        o_stamp_ena  <= 1'b0;
        o_xor_ena    <= 1'b0;
        o_output_ena <= 1'b0;
        o_pass       <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (r_win == CW'(WINDOW_LEN)) begin
              r_state      <= FLUSH;
              r_fl         <= '0;
              o_stamp_ena  <= 1'b0;
              o_xor_ena    <= 1'b0;
              o_output_ena <= 1'b0;
            end else begin
              r_win       <= r_win + 1'b1;
              r_phase     <= r_phase + 1'b1;
              o_stamp_ena <= r_phase < i_duty;
            end
          end
          FLUSH: begin
            // the last in-flight bit lands on this edge, so judge on the post-update signature
            if (r_fl == FW'(XOR_LAT - 1)) begin
              r_state <= DONE;
              o_pass  <= w_sig_nxt == i_golden;
            end else
              r_fl <= r_fl + 1'b1;
          end
          default: begin
            // entry edge already presents phase 0, so the counter moves on to phase 1
            if (i_start) begin
              r_state      <= RUN;
              r_phase      <= DUTY_W'(1);
              r_win        <= CW'(1);
              o_stamp_ena  <= i_duty != '0;
              o_xor_ena    <= 1'b1;
              o_output_ena <= 1'b1;
              o_pass       <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule
